// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared state encoding and parameter defaults for the byte-wide SRAM initiator
package sram_ctrl_pkg;

    localparam int ADDR_W_DEF   = 8;
    localparam int DATA_W_DEF   = 8;
    localparam int WAIT_CYC_DEF = 1;
    localparam int CNT_W        = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        ACCESS  = 2'd2,
        RECOVER = 2'd3
    } state_t;

    // WAIT_CYC is legal over 0..15, so this truncation never loses bits in a legal build.
    function automatic logic [CNT_W-1:0] wait_load(input int wait_cyc);
        return CNT_W'(wait_cyc);
    endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// rtl/sram_ctrl_if.sv - request/response handshake and SRAM cell pins of the SRAM initiator
interface sram_ctrl_if #(
    parameter int ADDR_W = sram_ctrl_pkg::ADDR_W_DEF,
    parameter int DATA_W = sram_ctrl_pkg::DATA_W_DEF
);

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_write;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;
    logic              sram_oe;
    logic              sram_we;

    // Requester plus SRAM array side.
    modport master (
        output req_valid, req_write, req_addr, req_wdata, sram_rdata,
        input  req_ready, rsp_valid, rsp_write, rsp_rdata,
        input  sram_addr, sram_wdata, sram_oe, sram_we
    );

    // Controller side.
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, sram_rdata,
        output req_ready, rsp_valid, rsp_write, rsp_rdata,
        output sram_addr, sram_wdata, sram_oe, sram_we
    );

endinterface

// File: rtl/sram_wait_timer.sv
// rtl/sram_wait_timer.sv - loadable down-counter timing the ACCESS phase, with a zero flag
module sram_wait_timer
    import sram_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - SRAM initiator FSM; SRAM_CTRL_BACK2BACK_EN lets RECOVER accept the next request
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int WAIT_CYC = WAIT_CYC_DEF
) (
    input  logic     clk,
    input  logic     reset,
    sram_ctrl_if.slave bus
);

    state_t            state;
    state_t            state_nxt;
    logic              op_write;
    logic              ready;
    logic              accept;
    logic              oe_nxt;
    logic              we_nxt;
    logic              timer_zero;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              oe_q;
    logic              we_q;
    logic              rsp_valid_q;
    logic              rsp_write_q;

    sram_wait_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (state == SETUP),
        .en       (state == ACCESS),
        .load_val (wait_load(WAIT_CYC)),
        .zero     (timer_zero)
    );

    always_comb begin
        ready = 1'b0;
        if (!reset) begin
`ifdef SRAM_CTRL_BACK2BACK_EN
            ready = (state == IDLE) || (state == RECOVER);
`else
            ready = (state == IDLE);
`endif
        end
    end

    assign accept = bus.req_valid && ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (timer_zero) state_nxt = RECOVER;
            RECOVER: state_nxt = accept ? SETUP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are registered from the next state, so they can only rise entering ACCESS
    // and always drop entering RECOVER: one enable is ever live at a time.
    always_comb begin
        oe_nxt = 1'b0;
        we_nxt = 1'b0;
        if (state_nxt == ACCESS) begin
            oe_nxt = !op_write;
            we_nxt = op_write;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            op_write    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            oe_q        <= 1'b0;
            we_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            oe_q        <= oe_nxt;
            we_q        <= we_nxt;
            rsp_valid_q <= (state_nxt == RECOVER);
            if (accept) begin
                op_write <= bus.req_write;
                addr_q   <= bus.req_addr;
                wdata_q  <= bus.req_wdata;
            end
            if (state_nxt == RECOVER) begin
                rsp_write_q <= op_write;
            end
            if ((state == ACCESS) && (state_nxt == RECOVER) && !op_write) begin
                rdata_q <= bus.sram_rdata;
            end
        end
    end

    assign bus.req_ready  = ready;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_write  = rsp_write_q;
    assign bus.rsp_rdata  = rdata_q;
    assign bus.sram_addr  = addr_q;
    assign bus.sram_wdata = wdata_q;
    assign bus.sram_oe    = oe_q;
    assign bus.sram_we    = we_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - directed self-checking bench for sram_ctrl at WAIT_CYC 1, 0 and 15
module tb_sram_ctrl;

    localparam int W = 1;
`ifdef SRAM_CTRL_BACK2BACK_EN
    localparam int PERIOD = W + 3;
`else
    localparam int PERIOD = W + 4;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       v1;
    logic       vx;
    logic       req_write;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_n = 0;
    int acc_cyc [16];
    int we0, we15, lat0, lat15, a0, rsp_seen;
    logic prev_oe, prev_we;

    always #5 clk = ~clk;

    sram_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus ();
    sram_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus_w0 ();
    sram_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus_w15 ();

    assign bus.req_valid      = v1;
    assign bus.req_write      = req_write;
    assign bus.req_addr       = req_addr;
    assign bus.req_wdata      = req_wdata;
    assign bus_w0.req_valid   = vx;
    assign bus_w0.req_write   = req_write;
    assign bus_w0.req_addr    = req_addr;
    assign bus_w0.req_wdata   = req_wdata;
    assign bus_w0.sram_rdata  = 8'h00;
    assign bus_w15.req_valid  = vx;
    assign bus_w15.req_write  = req_write;
    assign bus_w15.req_addr   = req_addr;
    assign bus_w15.req_wdata  = req_wdata;
    assign bus_w15.sram_rdata = 8'h00;

    sram_ctrl #(.ADDR_W(8), .DATA_W(8), .WAIT_CYC(W))  dut     (.clk(clk), .reset(reset), .bus(bus));
    sram_ctrl #(.ADDR_W(8), .DATA_W(8), .WAIT_CYC(0))  dut_w0  (.clk(clk), .reset(reset), .bus(bus_w0));
    sram_ctrl #(.ADDR_W(8), .DATA_W(8), .WAIT_CYC(15)) dut_w15 (.clk(clk), .reset(reset), .bus(bus_w15));

    // Byte-cell model behind the main controller.
    logic [7:0] mem [256];
    always @(posedge clk) if (bus.sram_we) mem[bus.sram_addr] <= bus.sram_wdata;
    assign bus.sram_rdata = bus.sram_oe ? mem[bus.sram_addr] : 8'h00;

    always @(posedge clk) begin
        if (v1 && bus.req_ready && acc_n < 16) begin
            acc_cyc[acc_n] <= cyc;
            acc_n          <= acc_n + 1;
        end
        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("oe_we_excl", {29'd0, bus.sram_oe & bus.sram_we, bus_w0.sram_oe & bus_w0.sram_we,
                           bus_w15.sram_oe & bus_w15.sram_we}, 32'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic wr, input logic [7:0] a, input logic [7:0] d, input logic [7:0] exp_rd);
        int n;
        logic acc;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        v1        = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            tick();
            n++;
        end
        chk("wait_ready", bus.req_ready, 1);
        tick();
        v1 = 1'b0;
        chk("setup_oe", bus.sram_oe, 0);
        chk("setup_we", bus.sram_we, 0);
        chk("setup_addr", bus.sram_addr, a);
        if (wr) chk("setup_wdata", bus.sram_wdata, d);
        for (int k = 1; k <= W + 2; k++) begin
            tick();
            acc = (k <= W + 1);
            chk($sformatf("we_c%0d", k), bus.sram_we, wr && acc);
            chk($sformatf("oe_c%0d", k), bus.sram_oe, !wr && acc);
            chk($sformatf("rsp_valid_c%0d", k), bus.rsp_valid, k == W + 2);
            chk($sformatf("addr_hold_c%0d", k), bus.sram_addr, a);
            if (k == W + 2) begin
                chk("rsp_write", bus.rsp_write, wr);
                if (wr) chk("wdata_hold", bus.sram_wdata, d);
                else    chk("rsp_rdata", bus.rsp_rdata, exp_rd);
            end
        end
        tick();
        chk("rsp_pulse_end", bus.rsp_valid, 0);
        chk("back_idle_ready", bus.req_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        v1 = 1'b0; vx = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_oe", bus.sram_oe, 0);
        chk("rst_we", bus.sram_we, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_write", bus.rsp_write, 0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 0);
        chk("rst_addr", bus.sram_addr, 0);
        chk("rst_wdata", bus.sram_wdata, 0);
        chk("rst_ready_low", bus.req_ready, 0);
        reset = 1'b0;
        #1;
        chk("idle_ready", bus.req_ready, 1);
        chk("idle_ready_w0", bus_w0.req_ready, 1);
        chk("idle_ready_w15", bus_w15.req_ready, 1);

        // WAIT_CYC 0 and 15 instances: ACCESS length and response latency.
        req_write = 1'b1; req_addr = 8'h42; req_wdata = 8'h99; vx = 1'b1;
        tick();
        vx = 1'b0;
        we0 = 0; we15 = 0; lat0 = 0; lat15 = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (bus_w0.sram_we) we0++;
            if (bus_w15.sram_we) we15++;
            if (bus_w0.rsp_valid && lat0 == 0) lat0 = k;
            if (bus_w15.rsp_valid && lat15 == 0) lat15 = k;
        end
        chk("w0_access_len", we0, 1);
        chk("w0_latency", lat0, 2);
        chk("w15_access_len", we15, 16);
        chk("w15_latency", lat15, 17);

        do_op(1'b1, 8'h10, 8'hA5, 8'h00);
        do_op(1'b0, 8'h10, 8'h00, 8'hA5);
        do_op(1'b1, 8'hFF, 8'h5A, 8'h00);
        do_op(1'b0, 8'hFF, 8'h00, 8'h5A);

        // Back-to-back write then read with valid held throughout.
        a0 = acc_n;
        req_write = 1'b1; req_addr = 8'h20; req_wdata = 8'h3C; v1 = 1'b1;
        prev_oe = 1'b0; prev_we = 1'b0;
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("turnaround_dead", (prev_we & bus.sram_oe) | (prev_oe & bus.sram_we), 0);
            prev_oe = bus.sram_oe;
            prev_we = bus.sram_we;
            if (acc_n == a0 + 1) begin
                req_write = 1'b0;
                req_wdata = 8'h00;
            end
            if (acc_n >= a0 + 2) v1 = 1'b0;
        end
        chk("b2b_accepts", acc_n, a0 + 2);
        if (acc_n >= a0 + 2) chk("b2b_period", acc_cyc[a0+1] - acc_cyc[a0], PERIOD);
        chk("b2b_rdata", bus.rsp_rdata, 8'h3C);

        // Reset during the first ACCESS cycle of a write.
        req_write = 1'b1; req_addr = 8'h30; req_wdata = 8'h77; v1 = 1'b1;
        tick();
        v1 = 1'b0;
        tick();
        chk("abort_we_in_access", bus.sram_we, 1);
        reset = 1'b1;
        tick();
        chk("abort_we", bus.sram_we, 0);
        chk("abort_oe", bus.sram_oe, 0);
        chk("abort_rsp_valid", bus.rsp_valid, 0);
        chk("abort_addr", bus.sram_addr, 0);
        chk("abort_rdata_cleared", bus.rsp_rdata, 0);
        reset = 1'b0;
        #1;
        chk("abort_ready", bus.req_ready, 1);
        rsp_seen = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (bus.rsp_valid) rsp_seen++;
        end
        chk("abort_no_rsp", rsp_seen, 0);

        // Request presented together with reset is dropped.
        reset = 1'b1; v1 = 1'b1; req_write = 1'b0; req_addr = 8'h55;
        tick();
        v1 = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_req_addr", bus.sram_addr, 0);
        tick();
        chk("rst_req_idle", bus.req_ready, 1);
        chk("rst_req_oe", bus.sram_oe, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
